// File: rtl/waves_replay_pkg.sv
// -----------------------------------------------------------------------------
// waves_replay_pkg
// Shared types and helpers for the waves_replay playback engine.
//   state_e  : playback FSM states (IDLE, LOAD, WAIT, DONE)
//   rec_t    : one value-change record {delta, value, last} at default widths
//   sat_inc  : saturating increment for the 32-bit time counter
// No ports (package).
// -----------------------------------------------------------------------------
package waves_replay_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_DELTA_W = 16;
  localparam int unsigned TIME_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_DELTA_W-1:0] delta;
    logic [DEF_WIDTH-1:0]   value;
    logic                   last;
  } rec_t;

  // Counts up but sticks at all-ones instead of wrapping.
  function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
    return (&v) ? v : v + TIME_W'(1);
  endfunction

endpackage

// File: rtl/waves_replay_if.sv
// -----------------------------------------------------------------------------
// waves_replay_if
// Bundles the control, record-stream and replay-output signals of waves_replay.
//   Control : start, abort (pulses from the controller)
//   Record  : rec_valid/rec_ready handshake carrying rec_delta, rec_value,
//             rec_last
//   Output  : sig_out, sig_update (replayed bus and its change strobe)
//   Status  : busy, done, underrun, time_count
// Modports:
//   master : the record source / controller side
//   slave  : the playback engine side
// -----------------------------------------------------------------------------
interface waves_replay_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DELTA_W = 16
) ();
  import waves_replay_pkg::*;

  logic               start;
  logic               abort;
  logic               rec_valid;
  logic               rec_ready;
  logic [DELTA_W-1:0] rec_delta;
  logic [WIDTH-1:0]   rec_value;
  logic               rec_last;
  logic [WIDTH-1:0]   sig_out;
  logic               sig_update;
  logic               busy;
  logic               done;
  logic               underrun;
  logic [TIME_W-1:0]  time_count;

  modport master (
    output start, abort, rec_valid, rec_delta, rec_value, rec_last,
    input  rec_ready, sig_out, sig_update, busy, done, underrun, time_count
  );

  modport slave (
    input  start, abort, rec_valid, rec_delta, rec_value, rec_last,
    output rec_ready, sig_out, sig_update, busy, done, underrun, time_count
  );

endinterface

// File: rtl/waves_replay.sv
// -----------------------------------------------------------------------------
// waves_replay
// Plays back a stream of value-change records onto sig_out, spacing each
// apply by the record's cycle delta (delta 0 behaves as 1).
// Ports:
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : waves_replay_if.slave (control, record stream, output, status)
// Parameters:
//   WIDTH, DELTA_W : value and delta widths (must match the interface)
//   RESET_VALUE    : sig_out value after reset
// -----------------------------------------------------------------------------
module waves_replay
  import waves_replay_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEF_WIDTH,
  parameter int unsigned      DELTA_W     = DEF_DELTA_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic          clock,
  input  logic          reset_n,
  waves_replay_if.slave bus
);

  state_e              state_q, state_d;
  logic [DELTA_W-1:0]  cnt_q;
  logic [WIDTH-1:0]    pend_value_q;
  logic                pend_last_q;
  logic [WIDTH-1:0]    sig_out_q;
  logic                sig_update_q;
  logic                underrun_q;
  logic [TIME_W-1:0]   time_q;

  logic rec_ready;
  logic busy;
  logic done;
  logic apply;
  logic accept;
  logic cnt_zero;
  logic start_ok;

  // Cycles to wait after acceptance: max(delta,1)-1, so the apply lands
  // max(delta,1) edges after the accepting edge.
  function automatic logic [DELTA_W-1:0] first_cnt(input logic [DELTA_W-1:0] d);
    return (d == '0) ? '0 : d - DELTA_W'(1);
  endfunction

  assign cnt_zero = (cnt_q == '0);
  assign accept   = bus.rec_valid && rec_ready && !bus.abort;
  assign start_ok = bus.start && !bus.abort &&
                    ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic (abort wins over everything)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          if (accept) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_zero) begin
            if (pend_last_q)  state_d = ST_DONE;
            else if (!accept) state_d = ST_LOAD;  // source was late
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. rec_ready depends on registered state only, so the source
  // never sees a combinational path from rec_valid back to rec_ready.
  // ---------------------------------------------------------------------------
  always_comb begin
    rec_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    apply     = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        rec_ready = 1'b1;
        busy      = 1'b1;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (cnt_zero) begin
          apply     = !bus.abort;
          // Prefetch the next record in the apply cycle unless this is the end.
          rec_ready = !pend_last_q;
        end
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: pending record, countdown, replayed output, status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      pend_value_q <= '0;
      pend_last_q  <= 1'b0;
      sig_out_q    <= RESET_VALUE;
      sig_update_q <= 1'b0;
      underrun_q   <= 1'b0;
      time_q       <= '0;
    end else begin
      sig_update_q <= apply;
      if (apply) begin
        sig_out_q <= pend_value_q;
      end

      if (accept) begin
        pend_value_q <= bus.rec_value;
        pend_last_q  <= bus.rec_last;
        cnt_q        <= first_cnt(bus.rec_delta);
      end else if ((state_q == ST_WAIT) && !cnt_zero) begin
        cnt_q <= cnt_q - DELTA_W'(1);
      end

      // Next record missing at the apply instant: flag it, spacing restarts
      // from that record's acceptance.
      if (apply && !pend_last_q && !bus.rec_valid) begin
        underrun_q <= 1'b1;
      end

      if (start_ok) begin
        time_q     <= '0;
        underrun_q <= 1'b0;
      end else if (busy) begin
        time_q <= sat_inc(time_q);
      end
    end
  end

  assign bus.rec_ready  = rec_ready;
  assign bus.sig_out    = sig_out_q;
  assign bus.sig_update = sig_update_q;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.underrun   = underrun_q;
  assign bus.time_count = time_q;

endmodule

// File: tb/tb_waves_replay.sv
// -----------------------------------------------------------------------------
// tb_waves_replay
// Directed bench for waves_replay: fixed record tables, expected spacings and
// values worked out by hand, all comparisons through one checking task.
// -----------------------------------------------------------------------------
module tb_waves_replay;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  waves_replay_if #(.WIDTH(32), .DELTA_W(16)) bus ();

  waves_replay #(
    .WIDTH(32),
    .DELTA_W(16),
    .RESET_VALUE(32'h0)
  ) dut (
    .clock(clk),
    .reset_n(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [15:0] src_delta [8];
  logic [31:0] src_value [8];
  logic        src_last  [8];
  int          src_n   = 0;
  int          src_idx = 0;
  logic        src_en  = 1'b0;

  int          acc_q   [$];
  int          upd_cyc [$];
  logic [31:0] upd_val [$];

  int s;
  int saved_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("[chk] %s: 0x%0h ok", tag, obs);
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    if (src_en && (src_idx < src_n)) begin
      bus.rec_valid = 1'b1;
      bus.rec_delta = src_delta[src_idx];
      bus.rec_value = src_value[src_idx];
      bus.rec_last  = src_last[src_idx];
    end else begin
      bus.rec_valid = 1'b0;
      bus.rec_delta = '0;
      bus.rec_value = '0;
      bus.rec_last  = 1'b0;
    end
  endtask

  // One clock: note handshake before the edge, log updates after it.
  task automatic tick();
    logic hs;
    hs = bus.rec_valid && bus.rec_ready;
    @(posedge clk);
    cyc++;
    #1;
    if (hs) begin
      acc_q.push_back(cyc);
      src_idx++;
    end
    if (bus.sig_update) begin
      upd_cyc.push_back(cyc);
      upd_val.push_back(bus.sig_out);
      $display("[%0d] update sig_out=0x%0h", cyc, bus.sig_out);
    end
    drive_src();
  endtask

  task automatic set_rec(input int i, input logic [15:0] d, input logic [31:0] v, input logic l);
    src_delta[i] = d;
    src_value[i] = v;
    src_last[i]  = l;
  endtask

  task automatic new_trace(input int n);
    acc_q.delete();
    upd_cyc.delete();
    upd_val.delete();
    src_idx = 0;
    src_n   = n;
    src_en  = 1'b1;
    drive_src();
  endtask

  task automatic pulse_start(output int edge_no);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    edge_no = cyc;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int n = 0;
    while (!bus.done && (n < budget)) begin
      tick();
      n++;
    end
    check({tag, "_done"}, bus.done, 1);
  endtask

  task automatic wait_updates(input string tag, input int k, input int budget);
    int n = 0;
    while ((upd_cyc.size() < k) && (n < budget)) begin
      tick();
      n++;
    end
    check({tag, "_nupd"}, upd_cyc.size(), k);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    drive_src();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // ---------------- reset state ----------------
    check("rst_sig_out", bus.sig_out, 32'h0);
    check("rst_sig_update", bus.sig_update, 0);
    check("rst_rec_ready", bus.rec_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_underrun", bus.underrun, 0);
    check("rst_time", bus.time_count, 0);
    rst_n = 1'b1;
    tick();

    // ---------------- T1: three records, always valid ----------------
    set_rec(0, 16'd3, 32'hA, 1'b0);
    set_rec(1, 16'd1, 32'hB, 1'b0);
    set_rec(2, 16'd5, 32'hC, 1'b1);
    new_trace(3);
    pulse_start(s);
    check("t1_busy_after_start", bus.busy, 1);
    check("t1_ready_in_load", bus.rec_ready, 1);
    check("t1_time_cleared", bus.time_count, 0);
    run_until_done("t1", 40);
    check("t1_nupd", upd_cyc.size(), 3);
    if ((upd_cyc.size() >= 3) && (acc_q.size() >= 1)) begin
      check("t1_accept_lat", acc_q[0] - s, 1);
      check("t1_gap0", upd_cyc[0] - acc_q[0], 3);
      check("t1_val0", upd_val[0], 32'hA);
      check("t1_gap1", upd_cyc[1] - upd_cyc[0], 1);
      check("t1_val1", upd_val[1], 32'hB);
      check("t1_gap2", upd_cyc[2] - upd_cyc[1], 5);
      check("t1_val2", upd_val[2], 32'hC);
    end
    check("t1_sig_out", bus.sig_out, 32'hC);
    check("t1_underrun", bus.underrun, 0);
    check("t1_ready_done", bus.rec_ready, 0);
    check("t1_time", bus.time_count, 10);
    tick();
    check("t1_time_hold", bus.time_count, 10);
    check("t1_no_update", bus.sig_update, 0);

    // ---------------- T2: delta 0 after delta 2 ----------------
    set_rec(0, 16'd2, 32'h11, 1'b0);
    set_rec(1, 16'd0, 32'h22, 1'b1);
    new_trace(2);
    pulse_start(s);
    run_until_done("t2", 30);
    check("t2_nupd", upd_cyc.size(), 2);
    if ((upd_cyc.size() >= 2) && (acc_q.size() >= 1)) begin
      check("t2_gap0", upd_cyc[0] - acc_q[0], 2);
      check("t2_gap1", upd_cyc[1] - upd_cyc[0], 1);
      check("t2_val1", upd_val[1], 32'h22);
    end

    // ---------------- T3: source stall -> underrun ----------------
    set_rec(0, 16'd1, 32'h31, 1'b0);
    set_rec(1, 16'd2, 32'h32, 1'b1);
    new_trace(1);
    pulse_start(s);
    wait_updates("t3a", 1, 20);
    check("t3_underrun_set", bus.underrun, 1);
    check("t3_back_to_load", bus.rec_ready, 1);
    repeat (3) tick();
    src_n = 2;
    drive_src();
    run_until_done("t3", 30);
    check("t3_nupd", upd_cyc.size(), 2);
    if ((upd_cyc.size() >= 2) && (acc_q.size() >= 2)) begin
      check("t3_late_gap", upd_cyc[1] - acc_q[1], 2);
      check("t3_val1", upd_val[1], 32'h32);
    end
    check("t3_underrun_sticky", bus.underrun, 1);
    src_en = 1'b0;
    drive_src();
    pulse_start(s);
    check("t3_underrun_cleared", bus.underrun, 0);
    check("t3_time_cleared", bus.time_count, 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t3_abort_idle", bus.busy, 0);

    // ---------------- T4: abort in WAIT with cnt=3 ----------------
    set_rec(0, 16'd10, 32'h44, 1'b0);
    set_rec(1, 16'd1, 32'h45, 1'b1);
    new_trace(2);
    pulse_start(s);
    repeat (7) tick();          // accept at s+1 (cnt=9), now cnt=3
    if (acc_q.size() >= 1) check("t4_accept_lat", acc_q[0] - s, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("t4_busy", bus.busy, 0);
    check("t4_done", bus.done, 0);
    check("t4_ready", bus.rec_ready, 0);
    check("t4_sig_hold", bus.sig_out, 32'h32);
    check("t4_no_update", bus.sig_update, 0);
    repeat (12) tick();
    check("t4_nupd", upd_cyc.size(), 0);
    check("t4_sig_hold_late", bus.sig_out, 32'h32);

    // ---------------- T5: reset during WAIT ----------------
    set_rec(0, 16'd1, 32'h51, 1'b0);
    set_rec(1, 16'd6, 32'h52, 1'b0);
    set_rec(2, 16'd1, 32'h53, 1'b1);
    new_trace(3);
    pulse_start(s);
    wait_updates("t5a", 1, 20);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_sig_out", bus.sig_out, 32'h0);
    check("t5_rst_time", bus.time_count, 0);
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_ready", bus.rec_ready, 0);
    saved_idx = src_idx;
    repeat (3) tick();
    check("t5_no_consume", src_idx, saved_idx);
    rst_n = 1'b1;
    new_trace(3);
    pulse_start(s);
    run_until_done("t5", 40);
    check("t5_nupd", upd_cyc.size(), 3);
    if ((upd_cyc.size() >= 3) && (acc_q.size() >= 1)) begin
      check("t5_gap0", upd_cyc[0] - acc_q[0], 1);
      check("t5_val0", upd_val[0], 32'h51);
      check("t5_gap1", upd_cyc[1] - upd_cyc[0], 6);
      check("t5_val1", upd_val[1], 32'h52);
      check("t5_gap2", upd_cyc[2] - upd_cyc[1], 1);
      check("t5_val2", upd_val[2], 32'h53);
    end

    // ---------------- T6: start while busy is ignored ----------------
    set_rec(0, 16'd4, 32'h61, 1'b0);
    set_rec(1, 16'd3, 32'h62, 1'b1);
    new_trace(2);
    pulse_start(s);
    repeat (2) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t6_time_not_cleared", bus.time_count, 3);
    check("t6_still_busy", bus.busy, 1);
    run_until_done("t6", 30);
    check("t6_nupd", upd_cyc.size(), 2);
    if ((upd_cyc.size() >= 2) && (acc_q.size() >= 1)) begin
      check("t6_accept_lat", acc_q[0] - s, 1);
      check("t6_gap0", upd_cyc[0] - acc_q[0], 4);
      check("t6_gap1", upd_cyc[1] - upd_cyc[0], 3);
      check("t6_val1", upd_val[1], 32'h62);
    end
    check("t6_time", bus.time_count, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
